// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 pattern generator and self-synchronising checker, DW bits per clock.
// Bit DW-1 of every beat is earliest in time; the checker locks onto any PRBS stream of the selected mode.
module prbs_gen_chk #(
    parameter int unsigned DW          = 1,
    parameter int unsigned ERR_CNT_W   = 16,
    parameter int unsigned LOCK_CNT    = 64,
    parameter int unsigned UNLOCK_ERRS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 gen_inject,
    output logic [DW-1:0]        gen_data,
    output logic                 gen_valid,
    input  logic [DW-1:0]        rx_data,
    input  logic                 rx_valid,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_pulse
);

    localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W = $clog2(UNLOCK_ERRS + 1);
    localparam int unsigned NE_W  = $clog2(DW + 1);
    localparam int unsigned SUM_W = ERR_CNT_W + NE_W;

    localparam logic [RUN_W-1:0]     RUN_LOCK   = RUN_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]     BAD_UNLOCK = BAD_W'(UNLOCK_ERRS);
    localparam logic [SUM_W-1:0]     ERR_MAX    = SUM_W'({ERR_CNT_W{1'b1}});

    localparam logic [1:0] ST_SEED   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    function automatic logic [4:0] poly_len(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd7;
            2'd1:    return 5'd15;
            2'd2:    return 5'd23;
            default: return 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] poly_tap(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd6;
            2'd1:    return 5'd14;
            2'd2:    return 5'd18;
            default: return 5'd28;
        endcase
    endfunction

    function automatic logic [30:0] poly_mask(input logic [1:0] m);
        case (m)
            2'd0:    return 31'h0000_007f;
            2'd1:    return 31'h0000_7fff;
            2'd2:    return 31'h007f_ffff;
            default: return 31'h7fff_ffff;
        endcase
    endfunction

    function automatic logic lfsr_fb(input logic [30:0] s, input logic [1:0] m);
        return s[poly_len(m) - 5'd1] ^ s[poly_tap(m) - 5'd1];
    endfunction

    logic [1:0]           mode_q, mode_d;
    logic                 mode_chg;
    logic [4:0]           len;
    logic [30:0]          mask;

    logic [30:0]          gen_s_q, gen_s_d;
    logic [DW-1:0]        gen_data_q, gen_data_d;
    logic                 gen_valid_q, gen_valid_d;
    logic                 inj_pend_q, inj_pend_d;
    logic [DW-1:0]        beat;

    logic [30:0]          chk_s_q, chk_s_d;
    logic [1:0]           st_q, st_d;
    logic [4:0]           fill_q, fill_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic [BAD_W-1:0]     bad_q, bad_d;
    logic                 locked_q, locked_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [NE_W-1:0]      nerr;
    logic                 pred;
    logic [SUM_W-1:0]     err_sum;

    always_comb begin
        mode_d      = mode;
        mode_chg    = (mode != mode_q);
        len         = poly_len(mode);
        mask        = poly_mask(mode);
        gen_s_d     = gen_s_q;
        gen_data_d  = gen_data_q;
        gen_valid_d = 1'b0;
        inj_pend_d  = inj_pend_q | gen_inject;
        beat        = '0;
        if (mode_chg) begin
            gen_s_d = 31'd1;
        end else if (en) begin
            for (int unsigned i = 0; i < DW; i++) begin
                beat[DW-1-i] = gen_s_d[len - 5'd1];
                gen_s_d      = {gen_s_d[29:0], lfsr_fb(gen_s_d, mode)} & mask;
            end
            // the injected flip only touches the output, never the LFSR state
            beat[DW-1]  = beat[DW-1] ^ inj_pend_d;
            gen_data_d  = beat;
            gen_valid_d = 1'b1;
            inj_pend_d  = 1'b0;
        end
    end

    always_comb begin
        chk_s_d     = chk_s_q;
        st_d        = st_q;
        fill_d      = fill_q;
        run_d       = run_q;
        bad_d       = bad_q;
        locked_d    = locked_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        nerr        = '0;
        pred        = 1'b0;
        err_sum     = '0;
        if (mode_chg) begin
            st_d     = ST_SEED;
            fill_d   = '0;
            locked_d = 1'b0;
        end else if (rx_valid) begin
            // state may change mid-beat; later bits of the beat use the new state
            for (int unsigned i = 0; i < DW; i++) begin
                case (st_d)
                    ST_SEED: begin
                        chk_s_d = {chk_s_d[29:0], rx_data[DW-1-i]} & mask;
                        fill_d  = fill_d + 5'd1;
                        if (fill_d == len) begin
                            st_d  = ST_VERIFY;
                            run_d = '0;
                        end
                    end
                    ST_VERIFY: begin
                        pred    = lfsr_fb(chk_s_d, mode);
                        chk_s_d = {chk_s_d[29:0], pred} & mask;
                        if (rx_data[DW-1-i] != pred) begin
                            st_d   = ST_SEED;
                            fill_d = '0;
                        end else begin
                            run_d = run_d + RUN_W'(1);
                            if (run_d == RUN_LOCK) begin
                                st_d  = ST_LOCKED;
                                run_d = '0;
                                bad_d = '0;
                            end
                        end
                    end
                    default: begin
                        pred    = lfsr_fb(chk_s_d, mode);
                        chk_s_d = {chk_s_d[29:0], pred} & mask;
                        if (rx_data[DW-1-i] != pred) begin
                            nerr  = nerr + NE_W'(1);
                            run_d = '0;
                        end else begin
                            run_d = run_d + RUN_W'(1);
                            if (run_d == RUN_LOCK) begin
                                run_d = '0;
                                bad_d = '0;
                            end
                        end
                    end
                endcase
            end
            if (nerr != '0) begin
                err_pulse_d = 1'b1;
                bad_d       = bad_d + BAD_W'(1);
                if (bad_d == BAD_UNLOCK) begin
                    st_d   = ST_SEED;
                    fill_d = '0;
                end
                err_sum   = SUM_W'(err_cnt_q) + SUM_W'(nerr);
                err_cnt_d = (err_sum > ERR_MAX) ? '1 : err_sum[ERR_CNT_W-1:0];
            end
            locked_d = (st_d == ST_LOCKED);
        end
        if (clr_cnt) err_cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mode_q      <= '0;
            gen_s_q     <= 31'd1;
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
            inj_pend_q  <= 1'b0;
            chk_s_q     <= '0;
            st_q        <= ST_SEED;
            fill_q      <= '0;
            run_q       <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            gen_s_q     <= gen_s_d;
            gen_data_q  <= gen_data_d;
            gen_valid_q <= gen_valid_d;
            inj_pend_q  <= inj_pend_d;
            chk_s_q     <= chk_s_d;
            st_q        <= st_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            bad_q       <= bad_d;
            locked_q    <= locked_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign gen_data  = gen_data_q;
    assign gen_valid = gen_valid_q;
    assign locked    = locked_q;
    assign err_cnt   = err_cnt_q;
    assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk: a DW=8 loopback instance and a DW=1 instance with a small error counter,
// both compared every cycle against a sequence-level PRBS reference model.
module tb_prbs_gen_chk;

    localparam int MAXB = 262144;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en8, inj8, clr8, en1, inj1, clr1, flip1;
    logic [1:0]  mode8, mode1;
    logic [7:0]  gd8;
    logic        gv8, lk8, ep8;
    logic [15:0] ec8;
    logic [0:0]  gd1, rd1;
    logic        gv1, lk1, ep1;
    logic [3:0]  ec1;

    assign rd1 = gd1 ^ flip1;

    prbs_gen_chk #(.DW(8), .ERR_CNT_W(16), .LOCK_CNT(64), .UNLOCK_ERRS(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .mode(mode8), .gen_inject(inj8),
        .gen_data(gd8), .gen_valid(gv8), .rx_data(gd8), .rx_valid(gv8),
        .clr_cnt(clr8), .locked(lk8), .err_cnt(ec8), .err_pulse(ep8)
    );

    prbs_gen_chk #(.DW(1), .ERR_CNT_W(4), .LOCK_CNT(64), .UNLOCK_ERRS(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .gen_inject(inj1),
        .gen_data(gd1), .gen_valid(gv1), .rx_data(rd1), .rx_valid(gv1),
        .clr_cnt(clr1), .locked(lk1), .err_cnt(ec1), .err_pulse(ep1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: index 0 = DW=8 instance, 1 = DW=1 instance
    bit          m_seq [2][MAXB];
    int unsigned m_len [2];
    int unsigned m_k   [2];
    logic [1:0]  m_gmode [2];
    bit          m_ref [2][64];
    int unsigned m_rl  [2];
    logic [1:0]  m_prev [2];
    bit          m_pend [2];
    logic [7:0]  m_gd  [2];
    bit          m_gv  [2];
    int          m_ph  [2];
    int unsigned m_fill [2], m_run [2], m_bad [2], m_ec [2];
    bit          m_lk  [2], m_ep [2];

    function automatic int unsigned plen(input logic [1:0] m);
        case (m)
            2'd0: return 7;
            2'd1: return 15;
            2'd2: return 23;
            default: return 31;
        endcase
    endfunction

    function automatic int unsigned ptap(input logic [1:0] m);
        case (m)
            2'd0: return 6;
            2'd1: return 14;
            2'd2: return 18;
            default: return 28;
        endcase
    endfunction

    // seed 1 emits n-1 zeros then a one; afterwards o[m] = o[m-n] ^ o[m-t]
    task automatic seq_reset(input int u, input logic [1:0] m);
        int unsigned n;
        n = plen(m);
        for (int unsigned j = 0; j < n; j++) m_seq[u][j] = (j == n - 1);
        m_len[u]   = n;
        m_k[u]     = 0;
        m_gmode[u] = m;
    endtask

    task automatic get_bit(input int u, input int unsigned j, output bit b);
        int unsigned n, t;
        n = plen(m_gmode[u]);
        t = ptap(m_gmode[u]);
        while (m_len[u] <= j) begin
            if (m_len[u] >= MAXB) begin
                $display("FAIL model_capacity: got %0d expected below %0d", m_len[u], MAXB);
                $fatal(1, "model sequence buffer exhausted");
            end
            m_seq[u][m_len[u]] = m_seq[u][m_len[u] - n] ^ m_seq[u][m_len[u] - t];
            m_len[u]++;
        end
        b = m_seq[u][j];
    endtask

    task automatic model_reset(input int u);
        seq_reset(u, 2'd0);
        m_prev[u] = 2'd0; m_pend[u] = 1'b0; m_gd[u] = '0; m_gv[u] = 1'b0;
        m_ph[u] = 0; m_fill[u] = 0; m_run[u] = 0; m_bad[u] = 0; m_ec[u] = 0;
        m_lk[u] = 1'b0; m_ep[u] = 1'b0; m_rl[u] = 0;
    endtask

    task automatic model_step(input int u, input bit en, input logic [1:0] mode, input bit inj,
                              input bit clr, input logic [7:0] rxd, input bit rxv);
        bit chg, b, p, ep_n;
        int unsigned n, t, dw, unl, emax, nerr;
        logic [7:0] d;
        dw   = (u == 0) ? 8 : 1;
        unl  = (u == 0) ? 4 : 32;
        emax = (u == 0) ? 65535 : 15;
        chg  = (mode != m_prev[u]);
        m_prev[u] = mode;
        n = plen(mode);
        t = ptap(mode);
        ep_n = 1'b0;
        if (chg) begin
            m_ph[u] = 0; m_fill[u] = 0; m_lk[u] = 1'b0;
        end else if (rxv) begin
            nerr = 0;
            for (int unsigned i = 0; i < dw; i++) begin
                b = rxd[dw-1-i];
                if (m_ph[u] == 0) begin
                    m_ref[u][m_rl[u] % 64] = b; m_rl[u]++;
                    m_fill[u]++;
                    if (m_fill[u] == n) begin m_ph[u] = 1; m_run[u] = 0; end
                end else begin
                    p = m_ref[u][(m_rl[u] - n) % 64] ^ m_ref[u][(m_rl[u] - t) % 64];
                    m_ref[u][m_rl[u] % 64] = p; m_rl[u]++;
                    if (b != p) begin
                        if (m_ph[u] == 1) begin m_ph[u] = 0; m_fill[u] = 0; end
                        else begin nerr++; m_run[u] = 0; end
                    end else begin
                        m_run[u]++;
                        if (m_run[u] == 64) begin
                            if (m_ph[u] == 1) m_ph[u] = 2;
                            m_bad[u] = 0; m_run[u] = 0;
                        end
                    end
                end
            end
            if (nerr > 0) begin
                ep_n = 1'b1;
                m_bad[u]++;
                if (m_bad[u] == unl) begin m_ph[u] = 0; m_fill[u] = 0; end
                m_ec[u] = (m_ec[u] + nerr > emax) ? emax : m_ec[u] + nerr;
            end
            m_lk[u] = (m_ph[u] == 2);
        end
        if (clr) m_ec[u] = 0;
        m_ep[u] = ep_n;
        if (chg) begin
            seq_reset(u, mode);
            m_gv[u] = 1'b0;
            m_pend[u] = m_pend[u] | inj;
        end else if (en) begin
            d = '0;
            for (int unsigned i = 0; i < dw; i++) begin
                get_bit(u, m_k[u] + i, b);
                d[dw-1-i] = b;
            end
            d[dw-1] = d[dw-1] ^ (m_pend[u] | inj);
            m_pend[u] = 1'b0;
            m_k[u] += dw;
            m_gd[u] = d;
            m_gv[u] = 1'b1;
        end else begin
            m_gv[u] = 1'b0;
            m_pend[u] = m_pend[u] | inj;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, en8, mode8, inj8, clr8, m_gd[0], m_gv[0]);
        model_step(1, en1, mode1, inj1, clr1, {7'd0, m_gd[1][0] ^ flip1}, m_gv[1]);
        #1;
        check_eq("gen_data8", gd8, m_gd[0]);
        check_eq("gen_valid8", gv8, m_gv[0]);
        check_eq("locked8", lk8, m_lk[0]);
        check_eq("err_cnt8", ec8, m_ec[0]);
        check_eq("err_pulse8", ep8, m_ep[0]);
        check_eq("gen_data1", gd1, m_gd[1][0]);
        check_eq("gen_valid1", gv1, m_gv[1]);
        check_eq("locked1", lk1, m_lk[1]);
        check_eq("err_cnt1", ec1, m_ec[1]);
        check_eq("err_pulse1", ep1, m_ep[1]);
        inj8 = 1'b0; inj1 = 1'b0; clr8 = 1'b0; clr1 = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gd8"}, gd8, 0);
        check_eq({tag, "_gv8"}, gv8, 0);
        check_eq({tag, "_lk8"}, lk8, 0);
        check_eq({tag, "_ec8"}, ec8, 0);
        check_eq({tag, "_ep8"}, ep8, 0);
        check_eq({tag, "_gd1"}, gd1, 0);
        check_eq({tag, "_gv1"}, gv1, 0);
        check_eq({tag, "_lk1"}, lk1, 0);
        check_eq({tag, "_ec1"}, ec1, 0);
        check_eq({tag, "_ep1"}, ep1, 0);
    endtask

    bit obs1 [160];
    bit exp7 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int nb1, beats8, lock_beat8, pulses;
        bit seen8, first_gv1;
        rst_n = 1'b1; en8 = 0; en1 = 0; inj8 = 0; inj1 = 0; clr8 = 0; clr1 = 0; flip1 = 0;
        mode8 = 2'd3; mode1 = 2'd0;
        model_reset(0); model_reset(1);
        #12;
        check_all_zero("reset");
        #10;
        rst_n = 1'b0;
        en8 = 1'b1; en1 = 1'b1;

        // PRBS7 sequence on DW=1, PRBS31 lock latency on DW=8
        nb1 = 0; beats8 = 0; lock_beat8 = 999; seen8 = 1'b0;
        for (int c = 0; c < 140; c++) begin
            tick();
            if (c == 0) first_gv1 = gv1;
            if (lk8 && !seen8) begin lock_beat8 = beats8; seen8 = 1'b1; end
            if (gv8) beats8++;
            if (gv1 && nb1 < 160) begin obs1[nb1] = gd1[0]; nb1++; end
        end
        check_eq("gv1_first_clock", first_gv1, 1);
        for (int j = 0; j < 8; j++) begin
            check_eq($sformatf("prbs7_bit%0d", j), obs1[j], exp7[j]);
            check_eq($sformatf("prbs7_wrap_bit%0d", j), obs1[127 + j], exp7[j]);
        end
        check_eq("lock_beat8", lock_beat8, 12);

        // saturation of the 4-bit counter, then clear against an errored beat
        check_eq("lock1_pre_sat", lk1, 1);
        flip1 = 1'b1;
        repeat (20) tick();
        check_eq("err_cnt1_sat", ec1, 15);
        clr1 = 1'b1;
        tick();
        check_eq("err_cnt1_clr", ec1, 0);
        check_eq("err_pulse1_clr", ep1, 1);
        flip1 = 1'b0;
        repeat (5) tick();
        check_eq("lock1_post_sat", lk1, 1);

        // long clean loopback with random enable gaps
        beats8 = 0;
        for (int c = 0; c < 20000 && beats8 < 10000; c++) begin
            en8 = ($urandom_range(0, 15) != 0);
            tick();
            if (gv8) beats8++;
        end
        check_eq("long_run_beats", beats8 >= 10000, 1);
        check_eq("long_run_err_cnt", ec8, 0);
        check_eq("long_run_locked", lk8, 1);

        // single injection
        en8 = 1'b1; inj8 = 1'b1;
        pulses = 0;
        repeat (21) begin tick(); if (ep8) pulses++; end
        check_eq("inj1_pulses", pulses, 1);
        check_eq("inj1_err_cnt", ec8, 1);
        check_eq("inj1_locked", lk8, 1);
        clr8 = 1'b1;
        tick();
        check_eq("clr8", ec8, 0);

        // four errored beats without a clean window drop lock
        repeat (4) begin inj8 = 1'b1; tick(); end
        repeat (4) tick();
        check_eq("inj4_unlocked", lk8, 0);
        check_eq("inj4_err_cnt", ec8, 4);
        repeat (40) tick();
        check_eq("inj4_relocked", lk8, 1);
        check_eq("inj4_err_cnt_kept", ec8, 4);

        // mode change 3 -> 1 while locked
        mode8 = 2'd1;
        tick();
        check_eq("mchg_locked", lk8, 0);
        check_eq("mchg_gv", gv8, 0);
        tick();
        check_eq("mchg_gv_next", gv8, 1);
        check_eq("prbs15_beat0", gd8, 8'h00);
        tick();
        check_eq("prbs15_beat1", gd8, 8'h02);
        repeat (40) tick();
        check_eq("mchg_relocked", lk8, 1);
        check_eq("mchg_err_cnt", ec8, 4);

        // random mix of everything
        for (int c = 0; c < 3000; c++) begin
            en8  = ($urandom_range(0, 7) != 0);
            en1  = ($urandom_range(0, 7) != 0);
            inj8 = ($urandom_range(0, 99) == 0);
            inj1 = ($urandom_range(0, 99) == 0);
            clr8 = ($urandom_range(0, 399) == 0);
            clr1 = ($urandom_range(0, 399) == 0);
            flip1 = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1499) == 0) mode8 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1499) == 0) mode1 = 2'($urandom_range(0, 3));
            tick();
        end
        flip1 = 1'b0; en8 = 1'b1; en1 = 1'b1;
        repeat (300) tick();
        check_eq("pre_rst_locked8", lk8, 1);
        check_eq("pre_rst_locked1", lk1, 1);

        // asynchronous reset mid-cycle
        #2;
        rst_n = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset(0); model_reset(1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mode1 = 2'd0;
        nb1 = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) first_gv1 = gv1;
            if (gv1 && nb1 < 8) begin obs1[nb1] = gd1[0]; nb1++; end
        end
        check_eq("post_rst_gv1_first", first_gv1, 1);
        for (int j = 0; j < 8; j++)
            check_eq($sformatf("post_rst_prbs7_bit%0d", j), obs1[j], exp7[j]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
- Parametrised PRBS pattern generator and self-synchronising checker for link and pad bring-up on the Tiny Tapeout I/O.
- Four runtime-selectable polynomials (PRBS7/15/23/31) and DW bits per clock.
- Checker locks to an incoming stream, counts bit errors and declares loss of lock.
- Generator and checker share the mode select, so a loopback of gen_data to rx_data is a complete self-test.

Parameters:
DW, 1, bits generated/checked per clock (1..8); bit DW-1 is earliest in time
ERR_CNT_W, 16, width of saturating error counter
LOCK_CNT, 64, consecutive error-free bits required to declare lock
UNLOCK_ERRS, 4, errored beats (without an intervening LOCK_CNT clean run) that force loss of lock

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-high (1 = reset)
en  in  1  generator advance enable
mode  in  2  0=PRBS7 x^7+x^6+1, 1=PRBS15 x^15+x^14+1, 2=PRBS23 x^23+x^18+1, 3=PRBS31 x^31+x^28+1
gen_inject  in  1  single-cycle pulse: invert earliest bit of next generated beat
gen_data  out  DW  generated bits
gen_valid  out  1  gen_data holds a new beat this cycle
rx_data  in  DW  received bits
rx_valid  in  1  rx_data qualifier
clr_cnt  in  1  synchronous clear of err_cnt
locked  out  1  checker in LOCKED state
err_cnt  out  ERR_CNT_W  saturating count of errored bits while locked
err_pulse  out  1  1 for one cycle after any beat with >=1 errored bit while locked

Behaviour:
- Reset: generator state = seed 1 (bit0=1, others 0); checker in SEED with fill count 0; gen_data=0, gen_valid=0, locked=0, err_cnt=0, err_pulse=0.
- LFSR step (Fibonacci, order n, tap t per mode):
  - output bit = s[n-1];
  - new s[0] = s[n-1]^s[t-1];
  - s shifts up by one.
  - Register is 31 bits; bits >= n are held at 0.
- Generator, each clock with en=1:
  - advance DW steps;
  - gen_data <= the DW output bits, earliest in bit DW-1; gen_valid <= 1.
  - en=0: state and gen_data hold, gen_valid <= 0.
- Generator latency: one clock from en to gen_valid.
- gen_inject is XORed onto the earliest bit of that beat only; the LFSR state is unaffected.
  - gen_inject with en=0 is held pending until the next en=1 beat.
- Mode change (mode differs from registered value) in the same cycle:
  - generator reloads seed 1 and skips output that cycle (gen_valid=0);
  - checker returns to SEED, locked <= 0; err_cnt is retained.
- Checker acts only on rx_valid=1 beats. States:
  - SEED: shift received bits directly into the checker register.
    - After n bits have been received, go to VERIFY with run count 0.
    - The boundary may fall mid-beat; remaining bits of that beat are compared as VERIFY.
  - VERIFY: predict each bit with the LFSR step and compare with the received bit. The register advances on its own prediction.
    - Any mismatch -> SEED (fill 0).
    - Run count reaches LOCK_CNT -> LOCKED, locked <= 1, bad count 0.
  - LOCKED: free-running prediction; per-beat error count = popcount of mismatches.
    - err_cnt += count, saturating at all-ones.
    - err_pulse <= 1 if count > 0.
    - Errored beat: bad count += 1 and run count cleared. Clean bits add to run count; reaching LOCK_CNT clears bad count.
    - Bad count reaches UNLOCK_ERRS -> SEED, locked <= 0 in the same update.
- err_cnt, err_pulse and locked are registered: they update one clock after the rx beat.
- clr_cnt: err_cnt <= 0 next clock. clr_cnt wins over a simultaneous error increment; that beat's errors are discarded from err_cnt but still drive err_pulse and bad count.
- No errors are counted outside LOCKED.
- Reset asserted mid-operation returns every register to its reset value immediately, regardless of clk.

Test Plan:
- Reset, mode=0, DW=1, en=1 -> first 8 gen_data bits 0,0,0,0,0,0,1,0; the generator state equals seed again after exactly 127 beats; gen_valid=1 from the first clock after en.
- Loopback gen_data->rx_data, mode=3, DW=8 -> locked rises after 31 seed bits plus 64 verify bits; locked is 1 by beat 12 plus one clock, and err_cnt stays 0 for 10000 beats.
- Locked loopback, one gen_inject pulse -> exactly one err_pulse cycle, err_cnt=1, locked stays 1; 4 injections within fewer than 64 clean bits -> locked=0, then relock with err_cnt=4.
- ERR_CNT_W=4, rx_data forced to ~expected after lock (DW=1) -> err_cnt saturates at 15; clr_cnt together with an errored beat -> err_cnt=0.
- Mode change 3->1 while locked -> locked=0 next clock, gen_valid=0 for one cycle, generator restarts from seed; checker relocks on PRBS15 with err_cnt unchanged.
- Assert rst_n asynchronously mid-beat while locked -> all outputs 0 before the next clk edge; after release, behaviour matches the first test.
